// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit-request queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_tx_pkg;

  // Handshake FSM encoding: wait for a free transmitter, then for busy to rise, then for busy to fall.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT_HI = 2'b01,
    S_WAIT_LO = 2'b10
  } state_e;

  // Cycles allowed for the transmitter to raise busy after a pulse before the byte is abandoned.
  localparam int unsigned BUSY_TIMEOUT_DEF = 255;

  // Width of the busy-rise watchdog counter.
  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Circular byte store with read/write pointers, occupancy count and FULL/EMPTY decode.
// Latency: a push is visible in cnt_o/empty_o one cycle later; rd_dat_o is a combinational read of the head.
// Backpressure: a push into a full store is dropped (drop_o) unless a pop frees a slot in the same cycle.
module uart_tx_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_dat_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [PTR_W:0]        cnt_o,
  output logic                  drop_o
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        cnt_q, cnt_d;
  logic                  full;
  logic                  wr_en;

  // Status decode straight from the registered count; the count alone tells full from empty.
  assign full     = (cnt_q == CNT_FULL);
  assign full_o   = full;
  assign empty_o  = (cnt_q == '0);
  assign cnt_o    = cnt_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full store needs.
  assign wr_en  = push_i && (!full || pop_i);
  assign drop_o = push_i && full && !pop_i;

  // Next-state for pointers (silent wrap at DEPTH-1) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({wr_en, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset empties the store without touching the array.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  a_no_pop_when_empty : assert property (@(posedge clk_i) disable iff (rst_i) pop_i |-> cnt_q != '0);
  a_cnt_bounded       : assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CNT_FULL);

endmodule

// File: rtl/uart_tx_queue.sv
// Buffers controller bytes and releases them one at a time to the UART TX data synchronizer.
// Latency: push into an empty idle queue at edge t -> EMPTY low after t, UART_TX_VLD pulse one cycle later.
// Backpressure: a byte leaves only when idle and UART_TX_Busy=0; pushes into a full queue are dropped, OVERFLOW sticks.
module uart_tx_queue
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PTR_W        = 3,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_VLD,
  input  logic                  UART_TX_Busy,
  output logic [DATA_WIDTH-1:0] UART_TX_DATA,
  output logic                  UART_TX_VLD,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [PTR_W:0]        FIFO_CNT,
  output logic                  OVERFLOW,
  output logic                  TIMEOUT
);

  // The watchdog gives up on the edge where the count would reach BUSY_TIMEOUT,
  // so TIMEOUT is seen exactly BUSY_TIMEOUT cycles after the pulse.
  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(BUSY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [DATA_WIDTH-1:0] tx_dat_q, tx_dat_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  tmo_q, tmo_d;
  logic                  ovf_q, ovf_d;

  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PTR_W:0]        fifo_cnt;
  logic [DATA_WIDTH-1:0] head_dat;

  uart_tx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (WR_VLD),
    .push_dat_i (WR_DATA),
    .pop_i      (pop),
    .rd_dat_o   (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .cnt_o      (fifo_cnt),
    .drop_o     (drop)
  );

  assign UART_TX_DATA = tx_dat_q;
  assign UART_TX_VLD  = tx_vld_q;
  assign FULL         = fifo_full;
  assign EMPTY        = fifo_empty;
  assign FIFO_CNT     = fifo_cnt;
  assign OVERFLOW     = ovf_q;
  assign TIMEOUT      = tmo_q;

  // Handshake FSM: issue a byte when the transmitter is free, then track busy rise and fall.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    tx_dat_d = tx_dat_q;
    tx_vld_d = 1'b0;
    tmo_d    = 1'b0;
    pop      = 1'b0;
    ovf_d    = ovf_q | drop;
    case (state_q)
      S_IDLE: begin
        // Busy still high here means a stale frame is finishing; hold off.
        if (!fifo_empty && !UART_TX_Busy) begin
          pop      = 1'b1;
          tx_dat_d = head_dat;
          tx_vld_d = 1'b1;
          timer_d  = '0;
          state_d  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (UART_TX_Busy) begin
          timer_d = '0;
          state_d = S_WAIT_LO;
        end else if (timer_q == TMO_LAST) begin
          // Transmitter never took the byte: abandon it, no retry.
          timer_d = '0;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_WAIT_LO: begin
        if (!UART_TX_Busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, watchdog and output registers; reset also discards any in-flight byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      tx_dat_q <= '0;
      tx_vld_q <= 1'b0;
      tmo_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tx_dat_q <= tx_dat_d;
      tx_vld_q <= tx_vld_d;
      tmo_q    <= tmo_d;
      ovf_q    <= ovf_d;
    end
  end

  a_vld_single_cycle : assert property (@(posedge CLK) disable iff (RST) tx_vld_q |=> !tx_vld_q);
  a_data_only_on_pop : assert property (@(posedge CLK) disable iff (RST) !pop |=> $stable(tx_dat_q));

endmodule
